// File: rtl/simmem_pkg.sv
// Shared types and sizing constants for the simulated write-only memory controller.
// The write-address ingress stage takes its default FIFO depth and outstanding cap from here.
package simmem_pkg;

  localparam int unsigned IdWidth   = 6;
  localparam int unsigned AddrWidth = 32;

  localparam int unsigned WriteRespBankTotalCapacity = 16;

  localparam int unsigned WaddrIngressDepth          = 4;
  localparam int unsigned WaddrIngressMaxOutstanding = 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           burst_len;
    logic [2:0]           burst_size;
  } waddr_req_t;

endpackage

// File: rtl/simmem_waddr_ingress_if.sv
// Write-address handshake bundle between the requester, the ingress stage and the controller.
// The slave modport is the ingress stage's view; master is the view of the surrounding logic.
interface simmem_waddr_ingress_if;
  import simmem_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  waddr_req_t in_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  waddr_req_t out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/simmem_ingress_fifo.sv
// Small register FIFO for write-address requests: wrapping pointers plus a separate
// occupancy counter, so full/empty are plain compares on registered state.
module simmem_ingress_fifo
  import simmem_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned OccW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  waddr_req_t      data_i,
  output waddr_req_t      data_o,
  output logic [OccW-1:0] occupancy_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  waddr_req_t      mem_q [Depth];
  waddr_req_t      mem_d [Depth];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    mem_d  = mem_q;
    if (push_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  assign data_o      = mem_q[rptr_q];
  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == OccW'(Depth));
  assign empty_o     = (occ_q == '0);

endmodule

// File: rtl/simmem_waddr_ingress.sv
// Write-address ingress: buffers requests and caps in-flight writes ahead of the controller.
// Optional counters are enabled with `define SIMMEM_WADDR_INGRESS_STATS_EN.
module simmem_waddr_ingress
  import simmem_pkg::*;
#(
  parameter  int unsigned Depth          = WaddrIngressDepth,
  parameter  int unsigned MaxOutstanding = WaddrIngressMaxOutstanding,
  localparam int unsigned OccW           = $clog2(Depth) + 1,
  localparam int unsigned OutsW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  simmem_waddr_ingress_if.slave  bus,
  input  logic                   wresp_done_i,
  output logic [OccW-1:0]        occupancy_o,
  output logic [OutsW-1:0]       outstanding_o,
  output logic                   err_o
`ifdef SIMMEM_WADDR_INGRESS_STATS_EN
  ,
  output logic [31:0]            stat_accepted_o,
  output logic [31:0]            stat_throttle_cycles_o
`endif
);

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             throttled;
  logic [OutsW-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  simmem_ingress_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (bus.in_data_i),
    .data_o      (bus.out_data_o),
    .occupancy_o (occupancy_o),
    .full_o      (full),
    .empty_o     (empty)
  );

  // A response retiring this cycle frees a slot, so a throttled head may pop immediately.
  assign throttled       = (outstanding_q == OutsW'(MaxOutstanding));
  assign bus.in_ready_o  = !full;
  assign bus.out_valid_o = !empty && (!throttled || wresp_done_i);
  assign push            = bus.in_valid_i && !full;
  assign pop             = bus.out_valid_o && bus.out_ready_i;

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (pop && !wresp_done_i) begin
      outstanding_d = outstanding_q + OutsW'(1);
    end else if (!pop && wresp_done_i) begin
      if (outstanding_q == '0) begin
        err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - OutsW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

`ifdef SIMMEM_WADDR_INGRESS_STATS_EN
  logic [31:0] stat_accepted_q, stat_accepted_d;
  logic [31:0] stat_throttle_q, stat_throttle_d;

  always_comb begin
    stat_accepted_d = stat_accepted_q;
    stat_throttle_d = stat_throttle_q;
    if (push && (stat_accepted_q != '1)) begin
      stat_accepted_d = stat_accepted_q + 32'd1;
    end
    if (!empty && throttled && (stat_throttle_q != '1)) begin
      stat_throttle_d = stat_throttle_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_accepted_q <= '0;
      stat_throttle_q <= '0;
    end else begin
      stat_accepted_q <= stat_accepted_d;
      stat_throttle_q <= stat_throttle_d;
    end
  end

  assign stat_accepted_o        = stat_accepted_q;
  assign stat_throttle_cycles_o = stat_throttle_q;
`endif

endmodule

// File: tb/tb_simmem_waddr_ingress.sv
// Self-checking bench for simmem_waddr_ingress: cycle table for flow control plus
// hand sequences for throughput, throttling and mid-stream reset, with a data scoreboard.
module tb_simmem_waddr_ingress;
  import simmem_pkg::*;

  localparam int unsigned Depth  = WaddrIngressDepth;
  localparam int unsigned MaxOut = WaddrIngressMaxOutstanding;
  localparam int unsigned OccW   = $clog2(Depth) + 1;
  localparam int unsigned OutsW  = $clog2(MaxOut + 1);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             wresp_done_i = 1'b0;
  logic [OccW-1:0]  occupancy_o;
  logic [OutsW-1:0] outstanding_o;
  logic             err_o;
`ifdef SIMMEM_WADDR_INGRESS_STATS_EN
  logic [31:0]      stat_accepted_o;
  logic [31:0]      stat_throttle_cycles_o;
`endif

  simmem_waddr_ingress_if bus ();

  simmem_waddr_ingress dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (bus),
    .wresp_done_i  (wresp_done_i),
    .occupancy_o   (occupancy_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
`ifdef SIMMEM_WADDR_INGRESS_STATS_EN
    ,
    .stat_accepted_o        (stat_accepted_o),
    .stat_throttle_cycles_o (stat_throttle_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             in_valid;
    logic             out_ready;
    logic             wresp_done;
    logic             exp_in_ready;
    logic             exp_out_valid;
    logic [OccW-1:0]  exp_occ;
    logic [OutsW-1:0] exp_outs;
    logic             exp_err;
  } vec_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned next_id = 0;
  waddr_req_t  exp_q[$];
  vec_t        vecs[24];

  logic             s_ready;
  logic             s_valid;
  logic [OccW-1:0]  s_occ;
  logic [OutsW-1:0] s_outs;
  logic             s_err;

  function automatic waddr_req_t make_req(int unsigned n);
    waddr_req_t r;
    r.id         = n[IdWidth-1:0];
    r.addr       = 32'h1000_0000 + (n * 32'd64);
    r.burst_len  = n[7:0] ^ 8'h5A;
    r.burst_size = n[2:0];
    return r;
  endfunction

  function automatic vec_t mk(bit v, bit r, bit d, bit er, bit ev, int eo, int es, bit ee);
    vec_t x;
    x.in_valid      = v;
    x.out_ready     = r;
    x.wresp_done    = d;
    x.exp_in_ready  = er;
    x.exp_out_valid = ev;
    x.exp_occ       = OccW'(eo);
    x.exp_outs      = OutsW'(es);
    x.exp_err       = ee;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drive, sample just after, score handshakes, advance to next falling edge.
  task automatic applyStimulus(input logic v, input logic r, input logic d);
    waddr_req_t exp_data;
    bus.in_valid_i  = v;
    bus.out_ready_i = r;
    wresp_done_i    = d;
    bus.in_data_i   = make_req(next_id);
    #1;
    s_ready = bus.in_ready_o;
    s_valid = bus.out_valid_o;
    s_occ   = occupancy_o;
    s_outs  = outstanding_o;
    s_err   = err_o;
    if (bus.out_valid_o && r) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_pop", 64'd1, 64'd0);
      end else begin
        exp_data = exp_q.pop_front();
        checkOutput("sb_data", 64'(bus.out_data_o), 64'(exp_data));
      end
    end
    if (v && bus.in_ready_o) begin
      exp_q.push_back(make_req(next_id));
      next_id++;
    end
    @(negedge clk_i);
  endtask

  task automatic checkState(input string tag, input logic er, input logic ev,
                            input int eo, input int es, input logic ee);
    checkOutput({tag, ".in_ready"},    64'(s_ready), 64'(er));
    checkOutput({tag, ".out_valid"},   64'(s_valid), 64'(ev));
    checkOutput({tag, ".occupancy"},   64'(s_occ),   64'(eo));
    checkOutput({tag, ".outstanding"}, 64'(s_outs),  64'(es));
    checkOutput({tag, ".err"},         64'(s_err),   64'(ee));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Fill to full, hold a fifth request, drain, pop-with-retire, then underflow.
    vecs[0]  = mk(1,0,0, 1,0,0,0,0);
    vecs[1]  = mk(1,0,0, 1,1,1,0,0);
    vecs[2]  = mk(1,0,0, 1,1,2,0,0);
    vecs[3]  = mk(1,0,0, 1,1,3,0,0);
    vecs[4]  = mk(1,0,0, 0,1,4,0,0);
    vecs[5]  = mk(1,0,0, 0,1,4,0,0);
    vecs[6]  = mk(1,1,0, 0,1,4,0,0);
    vecs[7]  = mk(1,0,0, 1,1,3,1,0);
    vecs[8]  = mk(0,0,0, 0,1,4,1,0);
    vecs[9]  = mk(0,1,0, 0,1,4,1,0);
    vecs[10] = mk(0,1,0, 1,1,3,2,0);
    vecs[11] = mk(0,1,0, 1,1,2,3,0);
    vecs[12] = mk(0,1,0, 1,1,1,4,0);
    vecs[13] = mk(0,1,1, 1,0,0,5,0);
    vecs[14] = mk(0,0,1, 1,0,0,4,0);
    vecs[15] = mk(1,0,0, 1,0,0,3,0);
    vecs[16] = mk(0,1,1, 1,1,1,3,0);
    vecs[17] = mk(0,0,0, 1,0,0,3,0);
    vecs[18] = mk(0,0,1, 1,0,0,3,0);
    vecs[19] = mk(0,0,1, 1,0,0,2,0);
    vecs[20] = mk(0,0,1, 1,0,0,1,0);
    vecs[21] = mk(0,0,0, 1,0,0,0,0);
    vecs[22] = mk(0,0,1, 1,0,0,0,0);
    vecs[23] = mk(0,0,0, 1,0,0,0,1);

    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    bus.in_data_i   = make_req(0);
    repeat (2) @(negedge clk_i);
    #1;
    s_ready = bus.in_ready_o;
    s_valid = bus.out_valid_o;
    s_occ   = occupancy_o;
    s_outs  = outstanding_o;
    s_err   = err_o;
    checkState("reset", 1'b1, 1'b0, 0, 0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].out_ready, vecs[i].wresp_done);
      checkState($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                 int'(vecs[i].exp_occ), int'(vecs[i].exp_outs), vecs[i].exp_err);
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("tp_prime", 1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkState($sformatf("tp%0d", i), 1'b1, 1'b1, 1, 0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkState("tp_last", 1'b1, 1'b1, 1, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("tp_idle", 1'b1, 1'b0, 0, 0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkState($sformatf("thr_fill%0d", i), 1'b1, (i != 0), (i == 0) ? 0 : 1,
                 (i == 0) ? 0 : i - 1, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkState($sformatf("thr_hold%0d", i), 1'b1, 1'b0, 1, 8, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkState("thr_release", 1'b1, 1'b1, 1, 8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("thr_after", 1'b1, 1'b0, 0, 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("thr_drain%0d", i), 1'b1, 1'b0, 0, 8 - i, 1'b1);
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("pre_rst", 1'b1, 1'b1, 1, 0, 1'b1);
    #3;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    s_ready = bus.in_ready_o;
    s_valid = bus.out_valid_o;
    s_occ   = occupancy_o;
    s_outs  = outstanding_o;
    s_err   = err_o;
    checkState("rst_mid", 1'b1, 1'b0, 0, 0, 1'b0);
    bus.in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("post_rst_push", 1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("post_rst_pop", 1'b1, 1'b1, 1, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("post_rst_idle", 1'b1, 1'b0, 0, 1, 1'b0);
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
